// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: stage state encoding,
// control-field bundle and the default-width beat layout.
// Port summary: none (package only).
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Occupancy of the elastic stage. ST_SKID is only reachable when the
    // second (skid) entry is built in.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // WB / M controls plus the ALU zero flag, carried as one bundle.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic zero;
    } ctrl_t;

    // Beat layout at the default widths. Parametrised instances build the
    // same layout locally with their own DATA_W/REG_W.
    typedef struct packed {
        ctrl_t                  ctrl;
        logic [DATA_W_DEF-1:0]  add_result;
        logic [DATA_W_DEF-1:0]  alu_result;
        logic [DATA_W_DEF-1:0]  read_data2;
        logic [REG_W_DEF-1:0]   write_reg;
    } beat_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic W-bit valid/ready pipeline stage with optional 2-entry skid and flush.
// Latency: 1 cycle from accept to out_vld when empty; 1 beat/cycle sustained.
// Backpressure: SKID=1 -> in_rdy decoded from state (no comb path from out_rdy); SKID=0 -> in_rdy = out_rdy | !out_vld.
// Ports: Clk, Rst_n (sync, active-low), Flush; in_vld/in_rdy/in_dat upstream;
//        out_vld/out_rdy/out_dat downstream (out_dat always from the main register).
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    pipe_state_t  state_q;
    pipe_state_t  state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    logic accept;
    logic drain;
    logic load_main;
    logic load_main_from_skid;
    logic load_skid;

    assign out_vld = (state_q != ST_EMPTY);
    assign out_dat = main_q;

    // With the skid entry, readiness depends only on registered state, so an
    // out_rdy drop is absorbed by the skid and in_rdy falls one cycle later.
    assign in_rdy  = SKID ? (state_q != ST_SKID) : (out_rdy | ~out_vld);

    assign accept  = in_vld & in_rdy;
    assign drain   = out_vld & out_rdy;

    always_comb begin
        state_d             = state_q;
        load_main           = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_FULL;
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept && SKID) begin
                    // Downstream stalled while a beat was in flight: park it.
                    state_d   = ST_SKID;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_rdy is low here, so no accept can coincide.
                if (drain) begin
                    state_d             = ST_FULL;
                    load_main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush only drops occupancy; data registers keep their contents and
        // the beat currently presented may still be taken downstream.
        if (Flush) begin
            state_d             = ST_EMPTY;
            load_main           = 1'b0;
            load_main_from_skid = 1'b0;
            load_skid           = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_dat;
            end else if (load_main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_dat;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM pipeline register with bubble gating, PCSrc and forwarding tap.
// Latency: 1 cycle EX->MEM when empty; 1 beat/cycle while OutReady=1.
// Backpressure: SKID=1 absorbs one in-flight beat, InReady registered; SKID=0 InReady = OutReady | !OutValid.
// Ports: Clk, Rst_n (sync, active-low), Flush; In* EX beat with InValid/InReady;
//        Out* MEM beat with OutValid/OutReady; OutPCSrc; FwdValid/FwdReg/FwdData hazard tap.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,

    input  logic              InValid,
    output logic              InReady,
    input  logic              InRegWrite,
    input  logic              InMemToReg,
    input  logic              InBranch,
    input  logic              InMemRead,
    input  logic              InMemWrite,
    input  logic              InZero,
    input  logic [DATA_W-1:0] InAddResult,
    input  logic [DATA_W-1:0] InALUResult,
    input  logic [DATA_W-1:0] InReadData2,
    input  logic [REG_W-1:0]  InWriteReg,

    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutRegWrite,
    output logic              OutMemToReg,
    output logic              OutBranch,
    output logic              OutMemRead,
    output logic              OutMemWrite,
    output logic              OutZero,
    output logic [DATA_W-1:0] OutAddResult,
    output logic [DATA_W-1:0] OutALUResult,
    output logic [DATA_W-1:0] OutReadData2,
    output logic [REG_W-1:0]  OutWriteReg,
    output logic              OutPCSrc,

    output logic              FwdValid,
    output logic [REG_W-1:0]  FwdReg,
    output logic [DATA_W-1:0] FwdData
);

    // Same field order as ex_mem_pkg::beat_t, sized by this instance.
    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] add_result;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data2;
        logic [REG_W-1:0]  write_reg;
    } ex_mem_beat_t;

    localparam int BEAT_W = $bits(ex_mem_beat_t);

    ex_mem_beat_t in_beat;
    ex_mem_beat_t out_beat;
    logic         out_vld;

    always_comb begin
        in_beat                 = '0;
        in_beat.ctrl.reg_write  = InRegWrite;
        in_beat.ctrl.mem_to_reg = InMemToReg;
        in_beat.ctrl.branch     = InBranch;
        in_beat.ctrl.mem_read   = InMemRead;
        in_beat.ctrl.mem_write  = InMemWrite;
        in_beat.ctrl.zero       = InZero;
        in_beat.add_result      = InAddResult;
        in_beat.alu_result      = InALUResult;
        in_beat.read_data2      = InReadData2;
        in_beat.write_reg       = InWriteReg;
    end

    pipe_skid_buf #(
        .W    (BEAT_W),
        .SKID (SKID)
    ) u_stage (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Flush   (Flush),
        .in_vld  (InValid),
        .in_rdy  (InReady),
        .in_dat  (in_beat),
        .out_vld (out_vld),
        .out_rdy (OutReady),
        .out_dat (out_beat)
    );

    assign OutValid     = out_vld;

    // Side-effecting controls are masked by valid so a bubble, including the
    // stale contents left behind by a flush, can never write memory, the
    // register file or the PC.
    assign OutRegWrite  = out_vld & out_beat.ctrl.reg_write;
    assign OutMemRead   = out_vld & out_beat.ctrl.mem_read;
    assign OutMemWrite  = out_vld & out_beat.ctrl.mem_write;
    assign OutBranch    = out_vld & out_beat.ctrl.branch;

    assign OutMemToReg  = out_beat.ctrl.mem_to_reg;
    assign OutZero      = out_beat.ctrl.zero;
    assign OutAddResult = out_beat.add_result;
    assign OutALUResult = out_beat.alu_result;
    assign OutReadData2 = out_beat.read_data2;
    assign OutWriteReg  = out_beat.write_reg;

    assign OutPCSrc     = OutBranch & OutZero;

    // r0 is hardwired zero, so a write to it is never a forwarding source.
    assign FwdValid     = OutRegWrite & (OutWriteReg != '0);
    assign FwdReg       = OutWriteReg;
    assign FwdData      = OutALUResult;

endmodule
